// File: rtl/nand_switch_bist.sv
// N-input NAND built from pmos/nmos switches, with a registered output and a
// self-test sequencer that sweeps every input vector through the switch core.
module nand_switch_bist #(
    parameter int N_IN  = 2,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  a,
    input  logic             start,
    input  logic             inj,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N_IN-1:0]  fail_vec,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fail_q, fail_d;
    logic             pass_q, pass_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N_IN-1:0]  core_in;
    logic [N_IN-1:0]  gate_n;
    logic             mismatch;

    supply1 vdd;
    supply0 gnd;
    tri     y_hi;
    tri     y_lo;

    assign core_in = (state_q == APPLY || state_q == CHECK) ? vec_q : a;

    always_comb begin
        gate_n    = core_in;
        gate_n[0] = core_in[0] & ~inj;
    end

    // The network is built twice, one output node with a pullup and one with a
    // pulldown: a floating node reads differently on the two, so it is caught as a mismatch.
    genvar i;
    for (i = 0; i < N_IN; i++) begin : g_sw
        pmos p_hi (y_hi, vdd, gate_n[i]);
        pmos p_lo (y_lo, vdd, gate_n[i]);
        if (i < N_IN - 1) begin : g_mid
            tri d_hi;
            tri d_lo;
            if (i == 0) begin : g_bot
                nmos n_hi (d_hi, gnd, gate_n[i]);
                nmos n_lo (d_lo, gnd, gate_n[i]);
            end else begin : g_in
                nmos n_hi (d_hi, g_sw[i-1].g_mid.d_hi, gate_n[i]);
                nmos n_lo (d_lo, g_sw[i-1].g_mid.d_lo, gate_n[i]);
            end
        end else begin : g_top
            if (i == 0) begin : g_bot
                nmos n_hi (y_hi, gnd, gate_n[i]);
                nmos n_lo (y_lo, gnd, gate_n[i]);
            end else begin : g_in
                nmos n_hi (y_hi, g_sw[i-1].g_mid.d_hi, gate_n[i]);
                nmos n_lo (y_lo, g_sw[i-1].g_mid.d_lo, gate_n[i]);
            end
        end
    end

    pullup   pu_hi (y_hi);
    pulldown pd_lo (y_lo);

    assign mismatch = (y_hi !== ~&vec_q) || (y_lo !== ~&vec_q);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        flag_d  = flag_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                y_d = y_hi;
                if (start) begin
                    err_d   = '0;
                    fail_d  = '0;
                    flag_d  = 1'b0;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    state_d = APPLY;
                end
            end
            APPLY: state_d = CHECK;
            CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!flag_q) begin
                        fail_d = vec_q;
                        flag_d = 1'b1;
                    end
                end
                if (vec_q == '1) begin
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = APPLY;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == APPLY) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            flag_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
            y_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y        = y_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_nand_switch_bist.sv
// Bench for nand_switch_bist: a 2-input and a 4-input instance side by side.
module tb_nand_switch_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] a2;
    logic       start2, inj2;
    logic       y2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [1:0] fail2;
    logic [1:0] st2;

    logic [3:0] a4;
    logic       start4, inj4;
    logic       y4, busy4, done4, pass4;
    logic [4:0] err4;
    logic [3:0] fail4;
    logic [1:0] st4;

    int total = 0;
    int bad   = 0;

    logic [0:0]  exp_y_q[$];
    logic [16:0] exp_b_q[$];

    logic       s_busy, s_done, s_pass;
    logic [7:0] s_err, s_fail;

    nand_switch_bist #(.N_IN(2)) d2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .start(start2), .inj(inj2),
        .y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_vec(fail2), .state_o(st2)
    );

    nand_switch_bist #(.N_IN(4)) d4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .start(start4), .inj(inj4),
        .y(y4), .busy(busy4), .done(done4), .pass(pass4),
        .err_cnt(err4), .fail_vec(fail4), .state_o(st4)
    );

    task automatic sample(input int n);
        if (n == 2) begin
            s_busy = busy2; s_done = done2; s_pass = pass2;
            s_err  = {5'd0, err2}; s_fail = {6'd0, fail2};
        end else begin
            s_busy = busy4; s_done = done4; s_pass = pass4;
            s_err  = {3'd0, err4}; s_fail = {4'd0, fail4};
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (y2 !== 1'b1) begin bad++; $display("FAIL reset_y2 got=%b exp=1", y2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
        total++; if (done2 !== 1'b0) begin bad++; $display("FAIL reset_done2 got=%b exp=0", done2); end
        total++; if (pass2 !== 1'b0) begin bad++; $display("FAIL reset_pass2 got=%b exp=0", pass2); end
        total++; if (err2 !== 3'd0) begin bad++; $display("FAIL reset_err2 got=%0d exp=0", err2); end
        total++; if (fail2 !== 2'd0) begin bad++; $display("FAIL reset_fail2 got=%0d exp=0", fail2); end
        total++; if (y4 !== 1'b1) begin bad++; $display("FAIL reset_y4 got=%b exp=1", y4); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        logic [0:0] e;
        for (int v = 0; v < 4; v++) begin
            a2 = 2'(v);
            exp_y_q.push_back(~&a2);
            @(negedge clk);
            e = exp_y_q.pop_front();
            total++; if (y2 !== e) begin bad++; $display("FAIL normal2_y a=%0d got=%b exp=%b", v, y2, e); end
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 0) a4 = 4'hF;
            else if (k == 1) a4 = 4'hE;
            else a4 = 4'($urandom_range(0, 15));
            exp_y_q.push_back(~&a4);
            @(negedge clk);
            e = exp_y_q.pop_front();
            total++; if (y4 !== e) begin bad++; $display("FAIL normal4_y a=%h got=%b exp=%b", a4, y4, e); end
        end
    endtask

    task automatic test_bist(input int n, input logic inj_v, input bit hold);
        int         nv = 1 << n;
        int         e_err = 0;
        int         e_fail = 0;
        int         cnt = 0;
        int         dones = 0;
        logic [16:0] e;
        for (int v = 0; v < nv; v++) begin
            if (inj_v && v == nv - 1) begin
                if (e_err == 0) e_fail = v;
                e_err++;
            end
        end
        exp_b_q.push_back({(e_err == 0), 8'(e_err), 8'(e_fail)});
        if (n == 2) begin inj2 = inj_v; start2 = 1'b1; end
        else begin inj4 = inj_v; start4 = 1'b1; end
        @(negedge clk);
        if (!hold) begin start2 = 1'b0; start4 = 1'b0; end
        sample(n);
        while (s_busy === 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge clk);
            sample(n);
        end
        start2 = 1'b0; start4 = 1'b0;
        e = exp_b_q.pop_front();
        total++; if (cnt !== 2 * nv) begin bad++; $display("FAIL bist%0d_busy_len got=%0d exp=%0d", n, cnt, 2 * nv); end
        total++; if (s_done !== 1'b1) begin bad++; $display("FAIL bist%0d_done got=%b exp=1", n, s_done); end
        total++; if (s_pass !== e[16]) begin bad++; $display("FAIL bist%0d_pass got=%b exp=%b", n, s_pass, e[16]); end
        total++; if (s_err !== e[15:8]) begin bad++; $display("FAIL bist%0d_err got=%0d exp=%0d", n, s_err, e[15:8]); end
        total++; if (s_fail !== e[7:0]) begin bad++; $display("FAIL bist%0d_fail_vec got=%0h exp=%0h", n, s_fail, e[7:0]); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sample(n);
            if (s_done === 1'b1) dones++;
            if (s_busy === 1'b1) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL bist%0d_no_restart got=%0d exp=0", n, dones); end
        total++; if (s_pass !== e[16] || s_err !== e[15:8]) begin
            bad++; $display("FAIL bist%0d_hold got=%b/%0d exp=%b/%0d", n, s_pass, s_err, e[16], e[15:8]);
        end
        inj2 = 1'b0; inj4 = 1'b0;
    endtask

    task automatic test_mid_reset();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy2); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy2); end
        total++; if (err2 !== 3'd0) begin bad++; $display("FAIL midrst_err got=%0d exp=0", err2); end
        total++; if (pass2 !== 1'b0) begin bad++; $display("FAIL midrst_pass got=%b exp=0", pass2); end
        total++; if (done2 !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done2); end
        @(negedge clk);
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b exp=0", busy2); end
    endtask

    initial begin
        rst_n = 1'b1;
        a2 = '0; start2 = 1'b0; inj2 = 1'b0;
        a4 = '0; start4 = 1'b0; inj4 = 1'b0;
        test_reset();
        test_normal();
        test_bist(2, 1'b0, 1'b0);
        test_bist(2, 1'b1, 1'b0);
        test_bist(2, 1'b0, 1'b1);
        test_mid_reset();
        test_bist(2, 1'b0, 1'b0);
        test_bist(4, 1'b0, 1'b0);
        test_bist(4, 1'b1, 1'b0);
        test_normal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
